// File: rtl/custom_rptr_empty_if.sv
// rtl/custom_rptr_empty_if.sv - read-side pointer/empty bundle between FIFO read logic and its user
//
// Purpose : groups the read-domain request, synchronized write pointer and
//           status/address outputs of custom_rptr_empty into one bundle.
// Signals :
//   wptr_sync2_rdclk  Gray write pointer already synchronized to the read clock
//   rinc_i            read request for this cycle
//   clr_underflow_i   clears the sticky underflow flag
//   raddr_o           memory read address
//   rptr_g            registered Gray read pointer (to the write-side synchronizer)
//   rempty_o          registered empty flag
//   raempty_o         registered almost-empty flag
//   rcount_o          registered pessimistic fill count
//   runderflow_o      sticky read-while-empty flag
// Modports: master drives requests and consumes status; slave is the pointer block.

interface custom_rptr_empty_if #(
    parameter int ADDRSIZE = 4
);
    logic [ADDRSIZE:0]   wptr_sync2_rdclk;
    logic                rinc_i;
    logic                clr_underflow_i;
    logic [ADDRSIZE-1:0] raddr_o;
    logic [ADDRSIZE:0]   rptr_g;
    logic                rempty_o;
    logic                raempty_o;
    logic [ADDRSIZE:0]   rcount_o;
    logic                runderflow_o;

    modport master (
        output wptr_sync2_rdclk,
        output rinc_i,
        output clr_underflow_i,
        input  raddr_o,
        input  rptr_g,
        input  rempty_o,
        input  raempty_o,
        input  rcount_o,
        input  runderflow_o
    );

    modport slave (
        input  wptr_sync2_rdclk,
        input  rinc_i,
        input  clr_underflow_i,
        output raddr_o,
        output rptr_g,
        output rempty_o,
        output raempty_o,
        output rcount_o,
        output runderflow_o
    );
endinterface

// File: rtl/custom_rptr_empty.sv
// rtl/custom_rptr_empty.sv - async FIFO read pointer, empty/almost-empty, fill count and underflow
//
// Purpose : read-clock-domain half of an async FIFO. Keeps the binary and
//           Gray read pointers, and derives empty, almost-empty, a
//           pessimistic fill count and a sticky underflow flag from the
//           twice-synchronized Gray write pointer.
// Ports   :
//   rclk_i    read clock (only clock)
//   rrst_n_i  asynchronous active-low reset
//   bus       custom_rptr_empty_if.slave (pointer inputs, status outputs)

module custom_rptr_empty #(
    parameter int ADDRSIZE      = 4,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                  rclk_i,
    input  logic                  rrst_n_i,
    custom_rptr_empty_if.slave    bus
);

    localparam logic [ADDRSIZE:0] AE_TH = (ADDRSIZE+1)'(AEMPTY_THRESH);

    logic [ADDRSIZE:0] r_rbin;
    logic [ADDRSIZE:0] r_rptr_g;
    logic              r_rempty;
    logic              r_raempty;
    logic [ADDRSIZE:0] r_rcount;
    logic              r_runderflow;

    logic              w_rd_ok;
    logic [ADDRSIZE:0] w_rbinnext;
    logic [ADDRSIZE:0] w_rgraynext;
    logic [ADDRSIZE:0] w_wbin_s;
    logic [ADDRSIZE:0] w_count_next;

    // A read only advances the pointer while not empty; this is what makes
    // read-while-empty harmless to the memory contents.
    assign w_rd_ok     = bus.rinc_i & ~r_rempty;
    assign w_rbinnext  = r_rbin + {{ADDRSIZE{1'b0}}, w_rd_ok};
    assign w_rgraynext = (w_rbinnext >> 1) ^ w_rbinnext;

    // Gray-to-binary: binary bit i is the XOR of all Gray bits at or above i.
    always_comb begin
        w_wbin_s = '0;
        for (int i = 0; i <= ADDRSIZE; i++) begin
            w_wbin_s[i] = ^(bus.wptr_sync2_rdclk >> i);
        end
    end

    // Using the next read pointer lets a read that drains the last entry
    // flag empty on the same edge; the synchronized write pointer lags, so
    // the count can only under-report.
    assign w_count_next = w_wbin_s - w_rbinnext;

    always_ff @(posedge rclk_i or negedge rrst_n_i) begin
        if (!rrst_n_i) begin
            r_rbin       <= '0;
            r_rptr_g     <= '0;
            r_rempty     <= 1'b1;
            r_raempty    <= 1'b1;
            r_rcount     <= '0;
            r_runderflow <= 1'b0;
        end else begin
            r_rbin    <= w_rbinnext;
            r_rptr_g  <= w_rgraynext;
            r_rempty  <= (w_rgraynext == bus.wptr_sync2_rdclk);
            r_rcount  <= w_count_next;
            r_raempty <= (w_count_next <= AE_TH);
            // Set has priority over clear so a simultaneous error is not lost.
            if (bus.rinc_i && r_rempty) begin
                r_runderflow <= 1'b1;
            end else if (bus.clr_underflow_i) begin
                r_runderflow <= 1'b0;
            end
        end
    end

    assign bus.raddr_o      = r_rbin[ADDRSIZE-1:0];
    assign bus.rptr_g       = r_rptr_g;
    assign bus.rempty_o     = r_rempty;
    assign bus.raempty_o    = r_raempty;
    assign bus.rcount_o     = r_rcount;
    assign bus.runderflow_o = r_runderflow;

endmodule

// File: tb/tb_custom_rptr_empty.sv
// tb/tb_custom_rptr_empty.sv - directed self-checking bench for custom_rptr_empty

module tb_custom_rptr_empty;

    logic clk;
    logic rrst_n;
    int   errors;
    int   checks;

    logic [4:0] wb;
    logic [4:0] exp_rbin;
    logic [4:0] exp_count;
    logic       exp_empty;
    logic       exp_ae;
    logic       exp_uf;

    custom_rptr_empty_if #(.ADDRSIZE(4)) bus ();

    custom_rptr_empty #(
        .ADDRSIZE      (4),
        .AEMPTY_THRESH (2)
    ) u_dut (
        .rclk_i   (clk),
        .rrst_n_i (rrst_n),
        .bus      (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [4:0] gray(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    // One clock: drive inputs, advance the reference model, sample at +1.
    task automatic step(input logic rd, input logic clr);
        bus.rinc_i           = rd;
        bus.clr_underflow_i  = clr;
        bus.wptr_sync2_rdclk = gray(wb);
        @(posedge clk);
        if (rd && exp_empty) exp_uf = 1'b1;
        else if (clr)        exp_uf = 1'b0;
        if (rd && !exp_empty) exp_rbin = exp_rbin + 5'd1;
        exp_count = wb - exp_rbin;
        exp_empty = (exp_count == 5'd0);
        exp_ae    = (exp_count <= 5'd2);
        #1;
    endtask

    task automatic apply_reset();
        rrst_n               = 1'b0;
        bus.rinc_i           = 1'b0;
        bus.clr_underflow_i  = 1'b0;
        wb                   = 5'd0;
        bus.wptr_sync2_rdclk = 5'd0;
        exp_rbin = 5'd0; exp_count = 5'd0; exp_empty = 1'b1; exp_ae = 1'b1; exp_uf = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rrst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (bus.rempty_o !== 1'b1) begin errors++; $display("FAIL reset_rempty got=%0b exp=1", bus.rempty_o); end
        checks++; if (bus.raempty_o !== 1'b1) begin errors++; $display("FAIL reset_raempty got=%0b exp=1", bus.raempty_o); end
        checks++; if (bus.rcount_o !== 5'd0) begin errors++; $display("FAIL reset_rcount got=%0d exp=0", bus.rcount_o); end
        checks++; if (bus.rptr_g !== 5'd0) begin errors++; $display("FAIL reset_rptr_g got=%0b exp=0", bus.rptr_g); end
        checks++; if (bus.raddr_o !== 4'd0) begin errors++; $display("FAIL reset_raddr got=%0d exp=0", bus.raddr_o); end
        checks++; if (bus.runderflow_o !== 1'b0) begin errors++; $display("FAIL reset_runderflow got=%0b exp=0", bus.runderflow_o); end
    endtask

    task automatic test_fill();
        logic [3:0] ea [3]  = '{4'd1, 4'd2, 4'd3};
        logic [4:0] ec [3]  = '{5'd2, 5'd1, 5'd0};
        logic       ee [3]  = '{1'b0, 1'b0, 1'b1};
        wb = 5'd3;
        step(1'b0, 1'b0);
        checks++; if (bus.rempty_o !== 1'b0) begin errors++; $display("FAIL fill_rempty got=%0b exp=0", bus.rempty_o); end
        checks++; if (bus.rcount_o !== 5'd3) begin errors++; $display("FAIL fill_rcount got=%0d exp=3", bus.rcount_o); end
        checks++; if (bus.raempty_o !== 1'b0) begin errors++; $display("FAIL fill_raempty got=%0b exp=0", bus.raempty_o); end
        checks++; if (bus.raddr_o !== 4'd0) begin errors++; $display("FAIL fill_raddr0 got=%0d exp=0", bus.raddr_o); end
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b0);
            checks++; if (bus.raddr_o !== ea[k]) begin errors++; $display("FAIL fill_raddr[%0d] got=%0d exp=%0d", k, bus.raddr_o, ea[k]); end
            checks++; if (bus.rcount_o !== ec[k]) begin errors++; $display("FAIL fill_rcount[%0d] got=%0d exp=%0d", k, bus.rcount_o, ec[k]); end
            checks++; if (bus.raempty_o !== 1'b1) begin errors++; $display("FAIL fill_raempty[%0d] got=%0b exp=1", k, bus.raempty_o); end
            checks++; if (bus.rempty_o !== ee[k]) begin errors++; $display("FAIL fill_rempty[%0d] got=%0b exp=%0b", k, bus.rempty_o, ee[k]); end
        end
        checks++; if (bus.rptr_g !== 5'b00010) begin errors++; $display("FAIL fill_rptr_g got=%0b exp=00010", bus.rptr_g); end
        bus.rinc_i = 1'b0;
    endtask

    task automatic test_underflow();
        step(1'b1, 1'b0);
        checks++; if (bus.raddr_o !== 4'd3) begin errors++; $display("FAIL uf_raddr_hold got=%0d exp=3", bus.raddr_o); end
        checks++; if (bus.runderflow_o !== 1'b1) begin errors++; $display("FAIL uf_set got=%0b exp=1", bus.runderflow_o); end
        step(1'b0, 1'b0);
        checks++; if (bus.runderflow_o !== 1'b1) begin errors++; $display("FAIL uf_sticky got=%0b exp=1", bus.runderflow_o); end
        step(1'b0, 1'b1);
        checks++; if (bus.runderflow_o !== 1'b0) begin errors++; $display("FAIL uf_clear got=%0b exp=0", bus.runderflow_o); end
        step(1'b1, 1'b1);
        checks++; if (bus.runderflow_o !== 1'b1) begin errors++; $display("FAIL uf_set_wins got=%0b exp=1", bus.runderflow_o); end
        checks++; if (bus.rptr_g !== 5'b00010) begin errors++; $display("FAIL uf_rptr_hold got=%0b exp=00010", bus.rptr_g); end
        step(1'b0, 1'b0);
    endtask

    task automatic test_full_threshold();
        logic [4:0] c;
        apply_reset();
        wb = 5'd16;
        step(1'b0, 1'b0);
        checks++; if (bus.rcount_o !== 5'd16) begin errors++; $display("FAIL full_rcount got=%0d exp=16", bus.rcount_o); end
        checks++; if (bus.rempty_o !== 1'b0) begin errors++; $display("FAIL full_rempty got=%0b exp=0", bus.rempty_o); end
        checks++; if (bus.raempty_o !== 1'b0) begin errors++; $display("FAIL full_raempty got=%0b exp=0", bus.raempty_o); end
        for (int k = 1; k <= 14; k++) begin
            step(1'b1, 1'b0);
            c = 5'(16 - k);
            checks++; if (bus.rcount_o !== c) begin errors++; $display("FAIL thr_rcount[%0d] got=%0d exp=%0d", k, bus.rcount_o, c); end
            checks++; if (bus.raempty_o !== (c <= 5'd2)) begin errors++; $display("FAIL thr_raempty[%0d] got=%0b exp=%0b", k, bus.raempty_o, (c <= 5'd2)); end
        end
        bus.rinc_i = 1'b0;
    endtask

    task automatic test_wrap();
        int         addr_wraps;
        bit         rbin_wrap;
        logic [3:0] prev_addr;
        // Pre-fill: write pointer advances one entry per cycle, no reads.
        for (int k = 0; k < 6; k++) begin
            wb = wb + 5'd1;
            step(1'b0, 1'b0);
        end
        checks++; if (bus.rcount_o !== 5'd8) begin errors++; $display("FAIL wrap_prefill got=%0d exp=8", bus.rcount_o); end
        addr_wraps = 0;
        rbin_wrap  = 1'b0;
        prev_addr  = bus.raddr_o;
        for (int i = 0; i < 40; i++) begin
            if (i % 5 != 4) wb = wb + 5'd1;
            step(1'b1, 1'b0);
            if (prev_addr == 4'd15 && bus.raddr_o == 4'd0) addr_wraps++;
            if (exp_rbin == 5'd0) rbin_wrap = 1'b1;
            prev_addr = bus.raddr_o;
            checks++; if (bus.raddr_o !== exp_rbin[3:0]) begin errors++; $display("FAIL wrap_raddr[%0d] got=%0d exp=%0d", i, bus.raddr_o, exp_rbin[3:0]); end
            checks++; if (bus.rptr_g !== gray(exp_rbin)) begin errors++; $display("FAIL wrap_rptr_g[%0d] got=%0b exp=%0b", i, bus.rptr_g, gray(exp_rbin)); end
            checks++; if (bus.rcount_o !== exp_count) begin errors++; $display("FAIL wrap_rcount[%0d] got=%0d exp=%0d", i, bus.rcount_o, exp_count); end
            checks++; if (bus.rempty_o !== exp_empty) begin errors++; $display("FAIL wrap_rempty[%0d] got=%0b exp=%0b", i, bus.rempty_o, exp_empty); end
            checks++; if (bus.raempty_o !== exp_ae) begin errors++; $display("FAIL wrap_raempty[%0d] got=%0b exp=%0b", i, bus.raempty_o, exp_ae); end
        end
        bus.rinc_i = 1'b0;
        checks++; if (addr_wraps < 2) begin errors++; $display("FAIL wrap_addr_count got=%0d exp>=2", addr_wraps); end
        checks++; if (!rbin_wrap) begin errors++; $display("FAIL wrap_rbin got=0 exp=1"); end
        checks++; if (bus.runderflow_o !== 1'b0) begin errors++; $display("FAIL wrap_no_uf got=%0b exp=0", bus.runderflow_o); end
    endtask

    task automatic test_reset_mid();
        step(1'b1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            wb = wb + 5'd1;
            step(1'b0, 1'b0);
        end
        checks++; if (bus.rcount_o !== 5'd5) begin errors++; $display("FAIL mid_pre_rcount got=%0d exp=5", bus.rcount_o); end
        checks++; if (bus.runderflow_o !== 1'b1) begin errors++; $display("FAIL mid_pre_uf got=%0b exp=1", bus.runderflow_o); end
        rrst_n = 1'b0;
        #1;
        checks++; if (bus.rempty_o !== 1'b1) begin errors++; $display("FAIL mid_rempty got=%0b exp=1", bus.rempty_o); end
        checks++; if (bus.raempty_o !== 1'b1) begin errors++; $display("FAIL mid_raempty got=%0b exp=1", bus.raempty_o); end
        checks++; if (bus.rcount_o !== 5'd0) begin errors++; $display("FAIL mid_rcount got=%0d exp=0", bus.rcount_o); end
        checks++; if (bus.rptr_g !== 5'd0) begin errors++; $display("FAIL mid_rptr_g got=%0b exp=0", bus.rptr_g); end
        checks++; if (bus.raddr_o !== 4'd0) begin errors++; $display("FAIL mid_raddr got=%0d exp=0", bus.raddr_o); end
        checks++; if (bus.runderflow_o !== 1'b0) begin errors++; $display("FAIL mid_runderflow got=%0b exp=0", bus.runderflow_o); end
        wb = 5'd0;
        bus.wptr_sync2_rdclk = 5'd0;
        exp_rbin = 5'd0; exp_count = 5'd0; exp_empty = 1'b1; exp_ae = 1'b1; exp_uf = 1'b0;
        #1;
        rrst_n = 1'b1;
        step(1'b0, 1'b0);
        checks++; if (bus.rempty_o !== 1'b1) begin errors++; $display("FAIL post_rempty got=%0b exp=1", bus.rempty_o); end
        checks++; if (bus.rcount_o !== 5'd0) begin errors++; $display("FAIL post_rcount got=%0d exp=0", bus.rcount_o); end
        wb = 5'd1;
        step(1'b0, 1'b0);
        checks++; if (bus.rcount_o !== 5'd1) begin errors++; $display("FAIL post_rcount1 got=%0d exp=1", bus.rcount_o); end
        checks++; if (bus.rempty_o !== 1'b0) begin errors++; $display("FAIL post_rempty1 got=%0b exp=0", bus.rempty_o); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rrst_n = 1'b0;
        test_reset();
        test_fill();
        test_underflow();
        test_full_threshold();
        test_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
